// File: rtl/adpcm_tdm_tx.sv
// ADPCM code FIFO and MSB-first TDM serializer with frame sync and derived bit clock.
// Define ADPCM_TDM_TX_PARITY_EN to send odd parity in the bit slot after the code bits.
module adpcm_tdm_tx #(
  parameter int CLK_DIV    = 8,
  parameter int FRAME_BITS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rate,
  input  logic       tx_en,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  input  logic       clear_flags,
  output logic       ser_clk,
  output logic       ser_data,
  output logic       ser_fs,
  output logic       fifo_full,
  output logic       overflow,
  output logic       underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, load, pop, push;
  logic [6:0]    head;
  logic [BW-1:0] head_n;
  logic [4:0]    head_sr;
  logic [4:0]    sr;
  logic [BW-1:0] n, bc;
  logic          bit_val;
  logic          code_unused;

  // Upper code bits carry no information for any rate.
  assign code_unused = ^code_in[7:5];

  assign tick      = tx_en && (div_cnt == DW'(CLK_DIV - 1));
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign load      = tick && ((state == START) ||
                              (state == SHIFT && bc == BW'(FRAME_BITS - 1)));
  assign pop       = load && !empty;
  assign push      = code_valid && (!fifo_full || pop);
  assign head      = mem[rd_ptr];

  // Left-justify the head code so the shift register always emits from bit 4.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    head_n  = BW'(5);
    head_sr = head[4:0];
    case (head[6:5])
      2'b01:   begin head_n = BW'(4); head_sr = {head[3:0], 1'b0}; end
      2'b10:   begin head_n = BW'(3); head_sr = {head[2:0], 2'b0}; end
      2'b11:   begin head_n = BW'(2); head_sr = {head[1:0], 3'b0}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset)         div_cnt <= '0;
    else if (!tx_en)   div_cnt <= '0;
    else if (tick)     div_cnt <= '0;
    else               div_cnt <= div_cnt + DW'(1);
  end

  // NOTE: code storage is not reset; entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rate, code_in[4:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Set events take priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (code_valid && fifo_full && !pop) overflow <= 1'b1;
      else if (clear_flags)                overflow <= 1'b0;
      if (load && empty)                   underrun <= 1'b1;
      else if (clear_flags)                underrun <= 1'b0;
    end
  end

`ifdef ADPCM_TDM_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     par <= 1'b0;
    else if (load) par <= empty ? 1'b1 : ~^head_sr;
  end
  assign bit_val = (bc < n) ? sr[4] : ((bc == n) && par);
`else
  assign bit_val = (bc < n) && sr[4];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      n        <= '0;
      bc       <= '0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
      ser_fs   <= 1'b0;
    end else begin
      // Outputs are gated by tx_en so a disable clears the line on the very next edge.
      ser_clk  <= tx_en && (state == SHIFT) && (div_cnt < DW'(CLK_DIV / 2));
      ser_fs   <= tx_en && (state == SHIFT) && (bc == '0);
      ser_data <= tx_en && (state == SHIFT) && bit_val;
      if (!tx_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= START;
          default: begin
            if (load) begin
              state <= SHIFT;
              bc    <= '0;
              sr    <= empty ? '0 : head_sr;
              n     <= empty ? '0 : head_n;
            end else if (state == SHIFT && tick) begin
              bc <= bc + BW'(1);
              sr <= sr << 1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpcm_tdm_tx.sv
// Self-checking bench for adpcm_tdm_tx: decodes the serial line into frames and
// compares them with a queue-based model of the code FIFO and frame format.
module tb_adpcm_tdm_tx;

  localparam int CLK_DIV    = 8;
  localparam int FRAME_BITS = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef ADPCM_TDM_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rate = '0;
  logic       tx_en = 1'b0;
  logic [7:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       clear_flags = 1'b0;
  logic       ser_clk, ser_data, ser_fs, fifo_full, overflow, underrun;

  always #5 clk = ~clk;

  adpcm_tdm_tx #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .rate(rate), .tx_en(tx_en), .code_in(code_in),
    .code_valid(code_valid), .clear_flags(clear_flags), .ser_clk(ser_clk),
    .ser_data(ser_data), .ser_fs(ser_fs), .fifo_full(fifo_full),
    .overflow(overflow), .underrun(underrun)
  );

  typedef struct packed {logic [1:0] r; logic [4:0] c;} entry_t;

  entry_t                model_q[$];
  bit                    exp_ovf, exp_und;
  logic [FRAME_BITS-1:0] frames[$];
  int                    fs_times[$];
  int                    passed = 0;
  int                    total = 0;

  // Line monitor: samples on the far-end (falling) ser_clk edge, frames start at ser_fs.
  int                    cyc = 0;
  logic                  prev_sclk = 1'b0, prev_fs = 1'b0;
  logic [FRAME_BITS-1:0] cur;
  int                    nbits = 0;
  bit                    in_frame = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
      nbits    = 0;
    end else begin
      if (ser_fs && !prev_fs) fs_times.push_back(cyc);
      if (prev_sclk && !ser_clk) begin
        if (ser_fs) begin
          in_frame = 1'b1;
          nbits    = 0;
          cur      = '0;
        end
        if (in_frame) begin
          cur[FRAME_BITS-1-nbits] = ser_data;
          nbits++;
          if (nbits == FRAME_BITS) begin
            frames.push_back(cur);
            in_frame = 1'b0;
          end
        end
      end
    end
    prev_sclk = ser_clk;
    prev_fs   = ser_fs;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame image, bit 0 of the frame in the MSB: code bits MSB-first, optional parity, zero fill.
  function automatic logic [FRAME_BITS-1:0] frame_of(bit und, entry_t e);
    logic [FRAME_BITS-1:0] f;
    int n, ones, b;
    f    = '0;
    ones = 0;
    n    = und ? 0 : 5 - int'(e.r);
    for (int i = 0; i < n; i++) begin
      b = (int'(e.c) >> (n - 1 - i)) & 1;
      ones += b;
      f[FRAME_BITS-1-i] = b[0];
    end
    if (PAR) f[FRAME_BITS-1-n] = (ones % 2 == 0);
    return f;
  endfunction

  task automatic tick_n(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic write_code(logic [1:0] r, logic [4:0] c, bit clr = 1'b0, bit popping = 1'b0);
    entry_t e;
    e.r = r;
    e.c = c;
    rate        = r;
    code_in     = {3'($urandom), c};
    code_valid  = 1'b1;
    clear_flags = clr;
    tick_n(1);
    code_valid  = 1'b0;
    clear_flags = 1'b0;
    rate        = 2'($urandom);
    if (popping || model_q.size() < FIFO_DEPTH) begin
      model_q.push_back(e);
      if (clr) exp_ovf = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
    if (clr) exp_und = 1'b0;
  endtask

  task automatic clear();
    clear_flags = 1'b1;
    tick_n(1);
    clear_flags = 1'b0;
    exp_ovf = 1'b0;
    exp_und = 1'b0;
  endtask

  task automatic wait_frames(int k);
    int budget;
    budget = (k + 2) * FRAME_BITS * CLK_DIV + 4 * CLK_DIV;
    while (frames.size() < k && budget > 0) begin
      tick_n(1);
      budget--;
    end
    check("frames_seen", 32'(frames.size() >= k), 32'd1);
  endtask

  task automatic finish_frames(int k, string tag);
    entry_t                e;
    bit                    und;
    logic [FRAME_BITS-1:0] exp_f;
    wait_frames(k);
    tx_en = 1'b0;
    for (int i = 0; i < k; i++) begin
      und = (model_q.size() == 0);
      if (und) begin
        e = '0;
        exp_und = 1'b1;
      end else begin
        e = model_q.pop_front();
      end
      exp_f = frame_of(und, e);
      check($sformatf("%s_frame%0d", tag, i), (i < frames.size()) ? frames[i] : 'x, exp_f);
    end
    tick_n(1);
    check({tag, "_underrun"}, underrun, exp_und);
    check({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  task automatic run_frames(int k, string tag);
    frames.delete();
    fs_times.delete();
    tx_en = 1'b1;
    finish_frames(k, tag);
  endtask

  task automatic check_fs_period(int k, string tag);
    for (int i = 1; i < k; i++)
      check({tag, "_fs_period"}, (i < fs_times.size()) ? fs_times[i] - fs_times[i-1] : -1,
            FRAME_BITS * CLK_DIV);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;

    // Reset state
    tick_n(2);
    check("reset_outputs", {ser_clk, ser_data, ser_fs, fifo_full, overflow, underrun}, '0);
    reset = 1'b0;
    tick_n(2);

    // rate=01 code 0x0B: latency, frame bits, then an underrun frame
    write_code(2'b01, 5'h0B);
    frames.delete();
    fs_times.delete();
    tx_en = 1'b1;
    lat = 0;
    while (!ser_fs && lat < 4 * CLK_DIV) begin
      tick_n(1);
      lat++;
    end
    check("first_fs_latency", lat, CLK_DIV + 1);
    finish_frames(2, "rate01");
    check("rate01_literal", (frames.size() > 0) ? frames[0] : 'x, 8'b1011_0000);
    clear();
    check("clear_flags", {overflow, underrun}, 2'b00);

    // Mixed rates, back-to-back frames
    write_code(2'b00, 5'h1F);
    write_code(2'b11, 5'h02);
    write_code(2'b10, 5'h05);
    run_frames(3, "mixed");
    check_fs_period(3, "mixed");
    clear();
    for (int round = 0; round < 3; round++) begin
      repeat (3) write_code(2'($urandom), 5'($urandom));
      run_frames(3, "rand");
      check_fs_period(3, "rand");
      clear();
    end

    // Overflow with transmitter disabled
    repeat (4) write_code(2'($urandom), 5'($urandom));
    check("full_after_fill", fifo_full, 32'(model_q.size() == FIFO_DEPTH));
    check("no_overflow_yet", overflow, exp_ovf);
    write_code(2'($urandom), 5'($urandom));
    check("overflow_set", overflow, exp_ovf);
    check("still_full", fifo_full, 1'b1);
    run_frames(5, "ovf");
    clear();

    // Write on the pop cycle of a full FIFO is accepted
    repeat (4) write_code(2'($urandom), 5'($urandom));
    frames.delete();
    fs_times.delete();
    tx_en = 1'b1;
    tick_n(CLK_DIV - 1);
    write_code(2'($urandom), 5'($urandom), 1'b0, 1'b1);
    check("simul_no_overflow", overflow, exp_ovf);
    check("simul_full", fifo_full, 1'b1);
    finish_frames(6, "simul");
    clear();

    // Clear coinciding with a new overflow: the set wins
    repeat (4) write_code(2'($urandom), 5'($urandom));
    write_code(2'($urandom), 5'($urandom), 1'b1);
    check("clear_vs_overflow", overflow, exp_ovf);
    clear();
    check("overflow_cleared", overflow, 1'b0);

    // tx_en drop at bc=3: outputs clear next cycle, queued codes survive
    frames.delete();
    tx_en = 1'b1;
    tick_n(4 * CLK_DIV + 2);
    check("pre_drop_sclk", ser_clk, 1'b1);
    check("pre_drop_fs", ser_fs, 1'b0);
    void'(model_q.pop_front());
    tx_en = 1'b0;
    tick_n(1);
    check("drop_outputs", {ser_clk, ser_data, ser_fs}, 3'b000);
    check("drop_not_full", fifo_full, 32'(model_q.size() == FIFO_DEPTH));
    write_code(2'($urandom), 5'($urandom));
    check("drop_refill_full", fifo_full, 32'(model_q.size() == FIFO_DEPTH));
    run_frames(5, "resume");
    clear();

    // Asynchronous reset mid-frame at bc=2
    repeat (5) write_code(2'($urandom), 5'($urandom));
    check("pre_reset_overflow", overflow, exp_ovf);
    frames.delete();
    tx_en = 1'b1;
    tick_n(3 * CLK_DIV + 2);
    check("pre_reset_sclk", ser_clk, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {ser_clk, ser_data, ser_fs, fifo_full, overflow, underrun}, '0);
    model_q.delete();
    exp_ovf = 1'b0;
    exp_und = 1'b0;
    tick_n(1);
    frames.delete();
    fs_times.delete();
    reset = 1'b0;
    finish_frames(1, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adpcm_tdm_tx.md
Name: adpcm_tdm_tx

Overview:
- Output stage directly downstream of the ADPCM encoder.
- Accepts one parallel ADPCM code per sample period from the encoder output word and buffers it in a small FIFO.
- Serializes each code MSB-first into a fixed-length TDM frame with a frame-sync pulse and a derived serial bit clock, for the line/RF interface.

Parameters:
- CLK_DIV, 8: system clocks per serial bit period; even, ≥4.
- FRAME_BITS, 8: bit periods per frame; ≥6.
- FIFO_DEPTH, 4: code FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rate  in  2  code width select: 00=5 bits (40k), 01=4 (32k), 10=3 (24k), 11=2 (16k)
- tx_en  in  1  transmitter enable
- code_in  in  8  encoder code, right-justified in bits [4:0]; upper bits ignored
- code_valid  in  1  one-cycle write strobe for code_in
- clear_flags  in  1  one-cycle clear of sticky flags
- ser_clk  out  1  serial bit clock
- ser_data  out  1  serial data
- ser_fs  out  1  frame sync, high for bit 0 of each frame
- fifo_full  out  1  FIFO full
- overflow  out  1  sticky: write dropped while full
- underrun  out  1  sticky: frame started with FIFO empty

Behaviour:
- Reset (async, active-high): all outputs 0, FIFO empty, divider 0, FSM IDLE. Applies immediately, including mid-frame; the partial frame is abandoned with no tail bits.
- Divider: div_cnt counts 0..CLK_DIV-1 while tx_en=1, and is held at 0 while tx_en=0. tick asserts when div_cnt==CLK_DIV-1.
- ser_clk is registered: 1 while div_cnt < CLK_DIV/2, otherwise 0; 0 in IDLE. ser_data and ser_fs change together with the ser_clk rising edge. The far end samples on the falling edge.
- FIFO write: code_valid=1 and not full → store {rate, code_in[4:0]}. Write while full → drop the code, set overflow.
- FIFO pop occurs on the tick that starts a frame.
- Simultaneous pop and write on a full FIFO: the pop takes effect first and the write is accepted (no overflow).
- Rate is captured per code at write time. A later rate change does not alter queued codes.
- FSM:
  - IDLE: outputs 0. tx_en 0→1 → START at the next tick.
  - START: on tick, pop the head entry into shift register sr and width register N (5/4/3/2 from the stored rate). If empty, load sr=0, N=0, set underrun. Bit counter bc=0. Go to SHIFT.
  - SHIFT: bit period bc drives ser_fs=(bc==0). ser_data = sr[N-1-bc] for bc<N, otherwise 0. On tick, bc increments. At bc==FRAME_BITS-1 the tick transitions directly into START, so frames run back-to-back with no gap.
  - tx_en=0 in any state → IDLE at the end of the current clock; the frame is aborted; FIFO contents are kept.
- Latency: the first frame's ser_fs rises 1 clk after the first tick following tx_en rise, i.e. CLK_DIV+1 clks after tx_en goes high.
- Flags: clear_flags clears overflow and underrun. A set event in the same cycle wins. fifo_full is combinational from the FIFO count.
- N ≤ FRAME_BITS is guaranteed by the parameter rule FRAME_BITS ≥ 6.

Optional Feature:
- Macro: ADPCM_TDM_TX_PARITY_EN.
- Defined: bit position N of each frame carries odd parity over the N code bits. An underrun frame carries parity 1. Bits after N are 0.
- Undefined: bit position N is 0, same as the other fill bits.

Test Plan:
- Reset mid-frame: assert reset during SHIFT bc=2 → ser_clk/ser_data/ser_fs/flags = 0 within the same cycle; after release with tx_en=1, the first frame is an underrun frame.
- rate=01: write code 0x0B, tx_en=1 → ser_fs high on bit 0; ser_data bits 0..7 = 1,0,1,1,0,0,0,0. With the macro defined, bit 4 = 0 (three ones, odd parity already met).
- Mixed rates: queue 0x1F@00, 0x2@11, 0x5@10 → three consecutive frames with leading bits 11111, 10, 101, no gap frames, ser_fs exactly every 8×CLK_DIV clks.
- Overflow: FIFO_DEPTH=4, tx_en=0, write 5 codes → fifo_full=1, overflow=1, fifth code lost. Then tx_en=1 → four frames, then underrun=1.
- Simultaneous: full FIFO, code_valid on the pop cycle → no overflow, written code transmitted fifth. clear_flags on the same cycle as a new overflow → overflow stays 1.
- tx_en drop: deassert at SHIFT bc=3 → outputs 0 next cycle, FIFO count unchanged. Re-enable → a new frame starts from the next queued code.
